// File: rtl/module_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : module_mem_arbiter_pkg
// Description : Shared types and widths for the unified-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package module_mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Owner of the single memory port
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/module_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : module_wait_counter
// Description : 8-bit saturating wait counter with synchronous clear and
//               count enable; flags the increment that reaches LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
module module_wait_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic reached
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  // Count enabled cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  // High in the cycle whose increment brings the count up to LIMIT
  assign reached = en && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/module_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : module_mem_arbiter
// Description : Single-port memory arbiter between fetch and memory stage.
//               Data access has fixed priority, fetch data may be discarded
//               by a flush, and a sticky error flags a silent memory.
// Revision    : 1.0 - initial release
// ============================================================================
module module_mem_arbiter
  import module_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_if_o,
  output logic              stall_mem_o,
  output logic              err_o
);

  state_t state;
  state_t next_state;
  logic   discard;
  logic   busy;
  logic   if_pending;
  logic   dm_pending;
  logic   if_drop;
  logic   timeout_hit;

  // A requester whose valid pulse is out this cycle is already served
  assign if_pending = if_req_i & ~if_valid_o;
  assign dm_pending = dm_req_i & ~dm_valid_o;
  assign busy       = (state != IDLE);
  assign mem_req_o  = busy;
  // A flush arriving together with the ack still cancels the fetch
  assign if_drop    = discard | if_flush_i;

  // Stall requests; a core held in reset sees none
  assign stall_if_o  = rst_i & if_pending;
  assign stall_mem_o = rst_i & dm_pending;

  module_wait_counter #(
    .LIMIT (TIMEOUT)
  ) u_wait_counter (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .clr     (~busy),
    .en      (busy & ~mem_ack_i),
    .reached (timeout_hit)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: data side wins in IDLE, busy states wait for the ack
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (dm_pending) begin
          next_state = DM_BUSY;
        end else if (if_pending) begin
          next_state = IF_BUSY;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_ack_i) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latching, response capture, discard flag and sticky error
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      if_valid_o  <= 1'b0;
      dm_rdata_o  <= '0;
      dm_valid_o  <= 1'b0;
      discard     <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if_valid_o <= 1'b0;
      dm_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dm_pending) begin
            mem_we_o    <= dm_we_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
          end else if (if_pending) begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= if_addr_i;
          end
        end
        IF_BUSY: begin
          if (mem_ack_i) begin
            if (!if_drop) begin
              if_valid_o <= 1'b1;
              if_rdata_o <= mem_rdata_i;
            end
            discard <= 1'b0;
          end else if (if_flush_i) begin
            discard <= 1'b1;
          end
        end
        DM_BUSY: begin
          if (mem_ack_i) begin
            dm_valid_o <= 1'b1;
            dm_rdata_o <= mem_we_o ? '0 : mem_rdata_i;
          end
        end
        default: ;
      endcase
      if (timeout_hit) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_module_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_module_mem_arbiter
// Description : Self-checking bench for module_mem_arbiter: directed
//               scenarios followed by random requester/memory traffic, all
//               compared against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_module_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i, if_flush_i, dm_req_i, dm_we_i, mem_ack_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_valid_o, dm_valid_o, mem_req_o, mem_we_o;
  logic        stall_if_o, stall_mem_o, err_o;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: who owns the memory (0 none, 1 fetch, 2 data)
  int          m_owner;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  logic        m_we, m_if_valid, m_dm_valid, m_err;
  bit          m_cancel;
  int          m_waited;

  // Random requester bookkeeping
  bit if_done, dm_done;

  module_mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_flush_i  (if_flush_i),
    .if_rdata_o  (if_rdata_o),
    .if_valid_o  (if_valid_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_valid_o  (dm_valid_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .stall_if_o  (stall_if_o),
    .stall_mem_o (stall_mem_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
    m_if_rdata = '0; m_dm_rdata = '0; m_if_valid = 1'b0; m_dm_valid = 1'b0;
    m_err = 1'b0; m_cancel = 1'b0; m_waited = 0;
  endtask

  // Advance the model by one clock using the inputs present this cycle
  task automatic model_step();
    bit nv_if, nv_dm;
    if (!rst_i) begin
      model_reset();
      return;
    end
    nv_if = 1'b0;
    nv_dm = 1'b0;
    if (m_owner == 0) begin
      if (dm_req_i && !m_dm_valid) begin
        m_owner = 2; m_addr = dm_addr_i; m_we = dm_we_i; m_wdata = dm_wdata_i; m_waited = 0;
      end else if (if_req_i && !m_if_valid) begin
        m_owner = 1; m_addr = if_addr_i; m_we = 1'b0; m_waited = 0;
      end
    end else if (mem_ack_i) begin
      if (m_owner == 2) begin
        nv_dm = 1'b1;
        m_dm_rdata = m_we ? 32'd0 : mem_rdata_i;
      end else if (!(m_cancel || if_flush_i)) begin
        nv_if = 1'b1;
        m_if_rdata = mem_rdata_i;
      end
      m_cancel = 1'b0;
      m_owner  = 0;
    end else begin
      m_waited++;
      if (m_waited >= TMO) m_err = 1'b1;
      if (m_owner == 1 && if_flush_i) m_cancel = 1'b1;
    end
    m_if_valid = nv_if;
    m_dm_valid = nv_dm;
  endtask

  task automatic check_outputs();
    chk("mem_req",   32'(mem_req_o),   32'(m_owner != 0));
    chk("mem_we",    32'(mem_we_o),    32'(m_we));
    chk("mem_addr",  mem_addr_o,       m_addr);
    chk("mem_wdata", mem_wdata_o,      m_wdata);
    chk("if_valid",  32'(if_valid_o),  32'(m_if_valid));
    chk("if_rdata",  if_rdata_o,       m_if_rdata);
    chk("dm_valid",  32'(dm_valid_o),  32'(m_dm_valid));
    chk("dm_rdata",  dm_rdata_o,       m_dm_rdata);
    chk("stall_if",  32'(stall_if_o),  32'(rst_i & if_req_i & ~m_if_valid));
    chk("stall_mem", 32'(stall_mem_o), 32'(rst_i & dm_req_i & ~m_dm_valid));
    chk("err",       32'(err_o),       32'(m_err));
  endtask

  // One clock: settle, compare, advance model, move to just after the edge
  task automatic cycle();
    #1;
    if (!rst_i) model_reset();
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
  endtask

  initial begin
    // Reset with every input active
    rst_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = '1; if_flush_i = 1'b1;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = '1; dm_wdata_i = '1;
    mem_ack_i = 1'b1; mem_rdata_i = '1;
    model_reset();
    cycle(); cycle(); cycle();
    #1;
    chk("rst_mem_req",  32'(mem_req_o),   32'd0);
    chk("rst_stall_if", 32'(stall_if_o),  32'd0);
    chk("rst_stall_mem",32'(stall_mem_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o,       32'd0);
    idle_inputs();
    rst_i = 1'b1;
    cycle(); cycle();
    chk("post_rst_no_req", 32'(mem_req_o), 32'd0);

    // Fetch only, ack after three busy cycles
    if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
    cycle();
    chk("f_req_c1",  32'(mem_req_o), 32'd1);
    chk("f_addr_c1", mem_addr_o,     32'h0000_0010);
    cycle(); cycle();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0050_0093;
    cycle();
    mem_ack_i = 1'b0;
    chk("f_valid_c4", 32'(if_valid_o), 32'd1);
    chk("f_rdata_c4", if_rdata_o,      32'h0050_0093);
    cycle();
    if_req_i = 1'b0;
    cycle();

    // Simultaneous load and fetch, zero-wait memory
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0000_0100;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0020;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    cycle();
    chk("s_dm_addr_c1", mem_addr_o, 32'h0000_0100);
    cycle();
    chk("s_dm_valid_c2", 32'(dm_valid_o), 32'd1);
    chk("s_dm_rdata_c2", dm_rdata_o,      32'hDEAD_BEEF);
    chk("s_idle_c2",     32'(mem_req_o),  32'd0);
    mem_rdata_i = 32'h0000_0013;
    cycle();
    dm_req_i = 1'b0;
    chk("s_if_req_c3",  32'(mem_req_o), 32'd1);
    chk("s_if_addr_c3", mem_addr_o,     32'h0000_0020);
    cycle();
    chk("s_if_valid_c4", 32'(if_valid_o), 32'd1);
    cycle();
    if_req_i = 1'b0; mem_ack_i = 1'b0;
    cycle();

    // Store held until ack
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h0000_0200; dm_wdata_i = 32'h1234_5678;
    mem_rdata_i = 32'hFFFF_FFFF;
    cycle();
    for (int i = 0; i < 3; i++) begin
      chk("st_we",    32'(mem_we_o), 32'd1);
      chk("st_addr",  mem_addr_o,    32'h0000_0200);
      chk("st_wdata", mem_wdata_o,   32'h1234_5678);
      if (i == 2) mem_ack_i = 1'b1;
      cycle();
    end
    mem_ack_i = 1'b0;
    chk("st_valid", 32'(dm_valid_o), 32'd1);
    chk("st_rdata", dm_rdata_o,      32'd0);
    cycle();
    dm_req_i = 1'b0;
    chk("st_single_pulse", 32'(dm_valid_o), 32'd0);
    cycle();

    // Flush during fetch, fetch of the new address follows
    if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
    cycle(); cycle();
    if_flush_i = 1'b1; if_addr_i = 32'h0000_0080;
    cycle();
    if_flush_i = 1'b0;
    chk("fl_addr_frozen", mem_addr_o, 32'h0000_0040);
    cycle();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    cycle();
    mem_ack_i = 1'b0;
    chk("fl_no_valid_c5", 32'(if_valid_o), 32'd0);
    chk("fl_stall_c5",    32'(stall_if_o), 32'd1);
    cycle();
    chk("fl_req_c6",  32'(mem_req_o), 32'd1);
    chk("fl_addr_c6", mem_addr_o,     32'h0000_0080);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0073;
    cycle();
    mem_ack_i = 1'b0;
    chk("fl_valid_c7", 32'(if_valid_o), 32'd1);
    chk("fl_rdata_c7", if_rdata_o,      32'h0000_0073);
    cycle();
    if_req_i = 1'b0;
    cycle();

    // Timeout with a silent memory, then a late ack
    chk("to_err_before", 32'(err_o), 32'd0);
    if_req_i = 1'b1; if_addr_i = 32'h0000_0030;
    cycle();
    cycle(); cycle(); cycle();
    chk("to_err_c4", 32'(err_o), 32'd0);
    cycle();
    chk("to_err_c5", 32'(err_o), 32'd1);
    cycle(); cycle(); cycle();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_ABCD;
    cycle();
    mem_ack_i = 1'b0;
    chk("to_valid", 32'(if_valid_o), 32'd1);
    chk("to_err_sticky", 32'(err_o), 32'd1);
    cycle();
    if_req_i = 1'b0;
    cycle();

    // Reset in the middle of a fetch abandons it
    if_req_i = 1'b1; if_addr_i = 32'h0000_0050;
    cycle(); cycle();
    rst_i = 1'b0; if_req_i = 1'b0;
    cycle();
    rst_i = 1'b1; mem_ack_i = 1'b1;
    cycle(); cycle();
    chk("mr_no_valid", 32'(if_valid_o), 32'd0);
    chk("mr_err_clr",  32'(err_o),      32'd0);
    mem_ack_i = 1'b0;

    // Random traffic against the model
    if_done = 1'b0; dm_done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!if_req_i || if_done) begin
        if_req_i  = ($urandom_range(0, 2) != 0);
        if_addr_i = $urandom() & 32'hFFFF_FFFC;
      end
      if (!dm_req_i || dm_done) begin
        dm_req_i   = ($urandom_range(0, 2) == 0);
        dm_we_i    = $urandom_range(0, 1) == 1;
        dm_addr_i  = $urandom() & 32'hFFFF_FFFC;
        dm_wdata_i = $urandom();
      end
      if_flush_i = ($urandom_range(0, 7) == 0);
      if (if_flush_i) if_addr_i = $urandom() & 32'hFFFF_FFFC;
      mem_ack_i   = ($urandom_range(0, 2) == 0);
      mem_rdata_i = $urandom();
      if_done = m_if_valid;
      dm_done = m_dm_valid;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/module_mem_arbiter.md
# module_mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the fetch stage and the memory stage of the RV32I pipelined core. It serialises requests, gives the older memory-stage access priority, and produces the fetch and memory stall requests consumed by the hazard unit. It also discards fetch data cancelled by a branch-prediction flush and flags a memory that never acknowledges.

## Interface
Parameters:
- TIMEOUT, 255: cycles a granted access may wait for mem_ack_i before err_o is raised. Legal range 1..255; the counter is 8 bits.

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request; held until if_valid_o
- if_addr_i  in  32  fetch address (PCF)
- if_flush_i  in  1  branch/mispredict flush from the hazard unit; cancels an in-flight fetch
- if_rdata_o  out  32  fetched instruction
- if_valid_o  out  1  one-cycle pulse; if_rdata_o is valid
- dm_req_i  in  1  load/store request; held until dm_valid_o
- dm_we_i  in  1  1 = store
- dm_addr_i  in  32  ALUResultM
- dm_wdata_i  in  32  WriteDataM
- dm_rdata_o  out  32  load data
- dm_valid_o  out  1  one-cycle completion pulse for loads and stores
- mem_req_o  out  1  memory request; held until acknowledged
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data; valid while mem_ack_i=1
- mem_ack_i  in  1  memory completion; sampled only while mem_req_o=1
- stall_if_o  out  1  stall request to the fetch/decode stages
- stall_mem_o  out  1  stall request to the memory stage and all older stages
- err_o  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, IF_BUSY, DM_BUSY.
- IDLE:
  - dm_req_i=1: go to DM_BUSY and latch dm_we_i, dm_addr_i and dm_wdata_i into the mem_* registers.
  - else if_req_i=1: go to IF_BUSY, latch if_addr_i, mem_we_o=0.
  - Data has fixed priority over fetch. When both requests arrive together, fetch waits.
- BUSY states:
  - mem_req_o=1 and the mem_* outputs stay frozen until mem_ack_i=1.
  - On ack: register mem_rdata_i into if_rdata_o or dm_rdata_o, pulse the matching valid for one cycle, return to IDLE.
  - For stores, dm_rdata_o is loaded with 0.
- Flush:
  - if_flush_i=1 in IF_BUSY sets a discard flag. The memory transaction still completes; it is never aborted.
  - On ack with discard set: no if_valid_o, flag cleared, return to IDLE.
  - if_flush_i in IDLE or DM_BUSY has no effect.
  - Flush and ack in the same cycle: data is discarded.
- Stalls (combinational from registered state):
  - stall_if_o = if_req_i & ~if_valid_o.
  - stall_mem_o = dm_req_i & ~dm_valid_o.
- Timeout:
  - An 8-bit wait counter clears on entry to a BUSY state and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT, err_o sets and stays set until reset.
  - The FSM keeps waiting. The counter saturates and does not wrap.
- Reset: the FSM goes to IDLE and every output, data register, discard flag and counter goes to 0, asynchronously.
- Reset asserted mid-transaction abandons the transaction; no valid pulse is produced.

## Timing
- Request seen in IDLE at cycle N gives mem_req_o=1 at N+1.
- Ack at cycle M gives the valid pulse and IDLE at M+1.
- Zero-wait memory (ack at N+1): valid at N+2, so the minimum latency is 2 cycles. One idle bubble follows each access.
- The next grant is decided in the IDLE cycle M+1, which is the same cycle as the valid pulse.
  - A requester whose request is satisfied in that cycle is not re-granted: the grant uses req & ~valid.
  - A fetch waiting behind a completing data access is granted in M+1, giving mem_req_o=1 at M+2.
- mem_ack_i while mem_req_o=0 is ignored.

## Structure
- Shared package module_mem_arbiter_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, IF_BUSY, DM_BUSY}
  - localparam ADDR_W=32 and DATA_W=32
- One sub-module, module_wait_counter (8-bit saturating counter with clear, enable and a reached-TIMEOUT output), instantiated once.
- All remaining logic is inline in module_mem_arbiter.

## Test plan
- Reset with rst_i=0 for 3 cycles, all inputs active -> every output is 0 and the FSM is IDLE; after release, no mem_req_o until a request.
- Fetch only: if_req_i=1 and if_addr_i=0x0000_0010 at cycle 0; memory acks at cycle 3 with rdata=0x0050_0093 -> mem_req_o high cycles 1–3 with mem_addr_o=0x10; if_valid_o pulses at cycle 4 with if_rdata_o=0x0050_0093; stall_if_o high cycles 0–3.
- Simultaneous requests: load at 0x100 and fetch at 0x20 in cycle 0; zero-wait memory with mem_rdata_i=0xDEAD_BEEF during the load ack -> load served first (dm_valid_o at 2, dm_rdata_o=0xDEAD_BEEF); fetch mem_req_o at 3; if_valid_o at 4.
- Store: dm_we_i=1, address 0x200, wdata 0x1234_5678 -> mem_we_o=1 with those values held until ack; dm_valid_o pulses once with dm_rdata_o=0.
- Flush: if_flush_i pulses at cycle 2 of an IF_BUSY access; ack at 4 -> no if_valid_o; stall_if_o stays high; fetch of the new address is granted in cycle 5.
- Timeout: TIMEOUT=4, mem_ack_i tied low -> err_o rises after 4 busy cycles and remains set; a later ack still completes the access with a valid pulse, and err_o stays 1.
